// File: rtl/sys_mem_pkg.sv
// Shared types and widths for the system memory subsystem.
// Pure declarations: no logic, no latency, no flow control.
package sys_mem_pkg;

    localparam int MEM_ADDR_W  = 14;
    localparam int MEM_RDATA_W = 8;
    localparam int MEM_WDATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DROP
    } mem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

endpackage

// File: rtl/sys_mem_array.sv
// Byte-wide storage: one registered read port, one 2-byte little-endian write port wrapping at the top.
// Latency: write commits at the enabling edge, read data registered one edge after rd_en.
// Backpressure: none, the controller issues at most one access per request.
module sys_mem_array
    import sys_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [MEM_WDATA_W-1:0] wr_data,
    output logic [MEM_RDATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr_hi;

    // Upper byte address wraps naturally in ADDR_W bits.
    assign wr_addr_hi = wr_addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr]    <= wr_data[7:0];
            mem[wr_addr_hi] <= wr_data[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sys_mem_ctrl.sv
// MSS controller: level-held read/write requests against a 16 KB byte array, four-phase mem_resp handshake.
// Latency: mem_resp rises LATENCY edges after acceptance; one DROP cycle after the request falls.
// Backpressure: requests are level-held until mem_resp; SYS_MEM_ERR_EN adds the sticky err output.
module sys_mem_ctrl
    import sys_mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   read_req,
    input  logic                   write_req,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [MEM_WDATA_W-1:0] wdata,
    output logic [MEM_RDATA_W-1:0] rdata,
    output logic                   mem_resp,
    output logic                   busy
`ifdef SYS_MEM_ERR_EN
    ,
    output logic                   err
`endif
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
            $error("sys_mem_ctrl: LATENCY must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    mem_state_t             state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    mem_op_t                op_q, op_nxt;
    logic [ADDR_W-1:0]      addr_q, addr_nxt;
    logic [MEM_WDATA_W-1:0] wdata_q, wdata_nxt;
    logic                   resp_nxt;
    logic                   orig_req;
    logic                   accept;
    logic                   rd_en, wr_en;

    // Only the request that started the access keeps it alive.
    assign orig_req = (op_q == OP_WR) ? write_req : read_req;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        resp_nxt  = mem_resp;
        accept    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (read_req || write_req) begin
                    accept    = 1'b1;
                    op_nxt    = write_req ? OP_WR : OP_RD;
                    addr_nxt  = addr;
                    wdata_nxt = wdata;
                    cnt_nxt   = 4'd1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!orig_req) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else if (cnt == LAT_CNT) begin
                    rd_en     = (op_q == OP_RD);
                    wr_en     = (op_q == OP_WR);
                    resp_nxt  = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                if (!orig_req) begin
                    resp_nxt  = 1'b0;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mem_resp <= 1'b0;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_resp <= resp_nxt;
            op_q     <= op_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
        end
    end

`ifdef SYS_MEM_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept && ((read_req && write_req) || (write_req && (addr == '1)))) begin
            err <= 1'b1;
        end
    end
`endif

    // Reset at the access edge must not commit anything.
    sys_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (rd_en && reset_n),
        .rd_addr (addr_q),
        .wr_en   (wr_en && reset_n),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_data (rdata)
    );

endmodule
